gate_controller: RTL and testbench

GATE_CONTROLLER -- requirements
Module: gate_controller

---
 rtl/parking_pkg.sv | 21 ++
 rtl/gate_controller_if.sv | 32 +++
 rtl/sensor_filter.sv | 61 ++++++
 rtl/gate_controller.sv | 122 ++++++++++++
 tb/tb_gate_controller.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate controller.
package parking_pkg;

    localparam int SLOT_W  = 2;
    localparam int CNT_W   = 16;
    localparam int TIMER_W = 8;

    typedef enum logic [1:0] {E_IDLE, E_REQ, E_LATCH, E_OPEN} entry_state_t;
    typedef enum logic [1:0] {X_IDLE, X_REQ, X_OPEN} exit_state_t;

    // Admission counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Open-timer step that stops at zero.
    function automatic logic [TIMER_W-1:0] tick_down(input logic [TIMER_W-1:0] t);
        return (t == '0) ? t : t - 1'b1;
    endfunction

endpackage

// File: rtl/gate_controller_if.sv
// Signal bundle between the gate controller and its surroundings (sensors, kiosk,
// slot manager, barriers, display). master = controller side.
interface gate_controller_if;
    import parking_pkg::*;

    logic              entry_sensor;
    logic              exit_sensor;
    logic [SLOT_W-1:0] exit_sel_in;
    logic              slot_available;
    logic [SLOT_W-1:0] allocated_slot;
    logic              alloc_req;
    logic              free_req;
    logic [SLOT_W-1:0] exit_car_select;
    logic              entry_gate_open;
    logic              exit_gate_open;
    logic [SLOT_W-1:0] assigned_slot;
    logic              lot_full;
    logic [CNT_W-1:0]  car_total;

    modport master (
        input  entry_sensor, exit_sensor, exit_sel_in, slot_available, allocated_slot,
        output alloc_req, free_req, exit_car_select, entry_gate_open, exit_gate_open,
               assigned_slot, lot_full, car_total
    );

    modport slave (
        output entry_sensor, exit_sensor, exit_sel_in, slot_available, allocated_slot,
        input  alloc_req, free_req, exit_car_select, entry_gate_open, exit_gate_open,
               assigned_slot, lot_full, car_total
    );

endinterface

// File: rtl/sensor_filter.sv
// Loop-sensor conditioning: 2-flop synchronizer, optional debounce (GATE_DEBOUNCE_EN),
// and a registered rising-edge pulse of the filtered value. Resets to "no car".
module sensor_filter #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt,
    output logic rise
);

    logic sync1, sync2, filt_prev;

    // Bring the asynchronous loop signal into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef GATE_DEBOUNCE_EN
    logic [7:0] db_cnt;
    logic       db_val;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt <= '0;
            db_val <= 1'b0;
        end else if (sync2 == db_val) begin
            db_cnt <= '0;
        end else if (db_cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
            db_val <= sync2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign filt = db_val;
`else
    assign filt = sync2;
`endif

    // One-cycle pulse on each filtered low-to-high transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_prev <= 1'b0;
            rise      <= 1'b0;
        end else begin
            filt_prev <= filt;
            rise      <= filt & ~filt_prev;
        end
    end

endmodule

// File: rtl/gate_controller.sv
// Parking-lot entry/exit barrier controller. Two independent FSMs drive the slot
// manager handshake and the barriers. Optional sensor debounce: GATE_DEBOUNCE_EN.
module gate_controller
    import parking_pkg::*;
#(
    parameter int unsigned OPEN_CYCLES     = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input logic               clk,
    input logic               rst,
    gate_controller_if.master bus
);

    localparam logic [TIMER_W-1:0] OPEN_LOAD = TIMER_W'(OPEN_CYCLES);

    logic entry_filt, entry_rise, exit_filt, exit_rise;
    entry_state_t e_state;
    exit_state_t  x_state;
    logic [TIMER_W-1:0] e_timer, x_timer;

    sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_filter (
        .clk  (clk),
        .rst  (rst),
        .raw  (bus.entry_sensor),
        .filt (entry_filt),
        .rise (entry_rise)
    );

    sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_filter (
        .clk  (clk),
        .rst  (rst),
        .raw  (bus.exit_sensor),
        .filt (exit_filt),
        .rise (exit_rise)
    );

    // Entry sequence: request a slot, latch it, hold the barrier open.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_state             <= E_IDLE;
            e_timer             <= '0;
            bus.alloc_req       <= 1'b0;
            bus.entry_gate_open <= 1'b0;
            bus.lot_full        <= 1'b0;
            bus.assigned_slot   <= '0;
            bus.car_total       <= '0;
        end else begin
            unique case (e_state)
                E_IDLE: begin
                    if (entry_rise) begin
                        if (bus.slot_available) begin
                            e_state       <= E_REQ;
                            bus.alloc_req <= 1'b1;
                            bus.lot_full  <= 1'b0;
                        end else begin
                            // Rejected car: no retry until it leaves and re-arrives.
                            bus.lot_full  <= 1'b1;
                        end
                    end else if (!entry_filt) begin
                        bus.lot_full <= 1'b0;
                    end
                end
                E_REQ: begin
                    bus.alloc_req <= 1'b0;
                    e_state       <= E_LATCH;
                end
                E_LATCH: begin
                    bus.assigned_slot   <= bus.allocated_slot;
                    bus.car_total       <= sat_inc(bus.car_total);
                    e_timer             <= OPEN_LOAD;
                    bus.entry_gate_open <= 1'b1;
                    e_state             <= E_OPEN;
                end
                E_OPEN: begin
                    e_timer <= tick_down(e_timer);
                    // A car still on the loop keeps the barrier up.
                    if (tick_down(e_timer) == '0 && !entry_filt) begin
                        bus.entry_gate_open <= 1'b0;
                        e_state             <= E_IDLE;
                    end
                end
                default: e_state <= E_IDLE;
            endcase
        end
    end

    // Exit sequence: release the keyed slot, hold the barrier open.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_state             <= X_IDLE;
            x_timer             <= '0;
            bus.free_req        <= 1'b0;
            bus.exit_gate_open  <= 1'b0;
            bus.exit_car_select <= '0;
        end else begin
            unique case (x_state)
                X_IDLE: begin
                    if (exit_rise) begin
                        x_state             <= X_REQ;
                        bus.free_req        <= 1'b1;
                        bus.exit_car_select <= bus.exit_sel_in;
                    end
                end
                X_REQ: begin
                    bus.free_req       <= 1'b0;
                    x_timer            <= OPEN_LOAD;
                    bus.exit_gate_open <= 1'b1;
                    x_state            <= X_OPEN;
                end
                X_OPEN: begin
                    x_timer <= tick_down(x_timer);
                    if (tick_down(x_timer) == '0 && !exit_filt) begin
                        bus.exit_gate_open <= 1'b0;
                        x_state            <= X_IDLE;
                    end
                end
                default: x_state <= X_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_controller.sv
// Self-checking bench for gate_controller: directed scenarios plus random sensor
// traffic, every cycle compared against an event/age based reference model.
module tb_gate_controller;
    import parking_pkg::*;

    localparam int OPEN = 8;
    localparam int DEB  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gate_controller_if bus ();

    gate_controller #(.OPEN_CYCLES(OPEN), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: filtered sensor from sample history, then each car
    // transaction tracked by its age in cycles since the request pulse.
    bit        sy1 [2], sy2 [2], fc [2], fo [2], rc [2], rv [2];
    int        rl [2];
    bit [1:0]  raw_v;
    bit        fnew;
    bit        e_act, x_act;
    int        e_age, x_age;
    bit        m_alloc, m_free, m_egate, m_xgate, m_lot;
    bit [1:0]  m_aslot, m_sel;
    bit [15:0] m_total;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                sy1[i] = 0; sy2[i] = 0; fc[i] = 0; fo[i] = 0; rc[i] = 0; rv[i] = 0; rl[i] = 0;
            end
            e_act = 0; x_act = 0; e_age = 0; x_age = 0;
            m_alloc = 0; m_free = 0; m_egate = 0; m_xgate = 0; m_lot = 0;
            m_aslot = 0; m_sel = 0; m_total = 0;
        end else begin
            m_alloc = 0;
            if (e_act) begin
                e_age++;
                if (e_age == 2) begin
                    m_egate = 1;
                    m_aslot = bus.allocated_slot;
                    if (m_total != 16'hFFFF) m_total++;
                end
                if (e_age >= OPEN + 2 && !fc[0]) begin
                    m_egate = 0;
                    e_act   = 0;
                end
            end else if (rc[0]) begin
                if (bus.slot_available) begin
                    e_act = 1; e_age = 0; m_alloc = 1; m_lot = 0;
                end else begin
                    m_lot = 1;
                end
            end else if (!fc[0]) begin
                m_lot = 0;
            end

            m_free = 0;
            if (x_act) begin
                x_age++;
                if (x_age == 1) m_xgate = 1;
                if (x_age >= OPEN + 1 && !fc[1]) begin
                    m_xgate = 0;
                    x_act   = 0;
                end
            end else if (rc[1]) begin
                x_act = 1; x_age = 0; m_free = 1; m_sel = bus.exit_sel_in;
            end

            raw_v = {bus.exit_sensor, bus.entry_sensor};
            for (int i = 0; i < 2; i++) begin
                rc[i] = fc[i] & ~fo[i];
`ifdef GATE_DEBOUNCE_EN
                if (sy2[i] == rv[i]) rl[i]++;
                else begin
                    rv[i] = sy2[i];
                    rl[i] = 1;
                end
                fnew = (rv[i] != fc[i] && rl[i] >= DEB) ? rv[i] : fc[i];
`else
                fnew = sy1[i];
`endif
                sy2[i] = sy1[i];
                sy1[i] = raw_v[i];
                fo[i]  = fc[i];
                fc[i]  = fnew;
            end
        end
    end

    // Observation bookkeeping, owned by the stimulus process only.
    int cyc = 0;
    int n_alloc = 0, n_free = 0, n_egate = 0, n_xgate = 0;
    int last_alloc = 0, last_free = 0, last_erise = 0, last_xrise = 0;
    bit eg_prev = 0, xg_prev = 0;

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!rst) begin
            if (bus.alloc_req) begin n_alloc++; last_alloc = cyc; end
            if (bus.free_req) begin n_free++; last_free = cyc; end
            if (bus.entry_gate_open) begin
                n_egate++;
                if (!eg_prev) last_erise = cyc;
            end
            if (bus.exit_gate_open) begin
                n_xgate++;
                if (!xg_prev) last_xrise = cyc;
            end
            eg_prev = bus.entry_gate_open;
            xg_prev = bus.exit_gate_open;
            check_eq("alloc_req", bus.alloc_req, m_alloc);
            check_eq("free_req", bus.free_req, m_free);
            check_eq("entry_gate_open", bus.entry_gate_open, m_egate);
            check_eq("exit_gate_open", bus.exit_gate_open, m_xgate);
            check_eq("lot_full", bus.lot_full, m_lot);
            check_eq("assigned_slot", bus.assigned_slot, m_aslot);
            check_eq("exit_car_select", bus.exit_car_select, m_sel);
            check_eq("car_total", bus.car_total, m_total);
        end else begin
            eg_prev = 0;
            xg_prev = 0;
        end
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_alloc"}, bus.alloc_req, 0);
        check_eq({tag, "_free"}, bus.free_req, 0);
        check_eq({tag, "_egate"}, bus.entry_gate_open, 0);
        check_eq({tag, "_xgate"}, bus.exit_gate_open, 0);
        check_eq({tag, "_lot_full"}, bus.lot_full, 0);
        check_eq({tag, "_aslot"}, bus.assigned_slot, 0);
        check_eq({tag, "_sel"}, bus.exit_car_select, 0);
        check_eq({tag, "_total"}, bus.car_total, 0);
    endtask

    int a0, f0, eg0, xg0;
    bit found;

    initial begin
        bus.entry_sensor   = 0;
        bus.exit_sensor    = 0;
        bus.exit_sel_in    = 0;
        bus.slot_available = 1;
        bus.allocated_slot = 0;
        repeat (3) tick();
        check_cleared("reset");
        rst = 0;
        repeat (3) tick();

        // Admission with a free slot; car leaves the loop early.
        a0 = n_alloc; eg0 = n_egate;
        bus.allocated_slot = 2;
        bus.entry_sensor = 1;
        repeat (6) tick();
        bus.entry_sensor = 0;
        repeat (30) tick();
        check_eq("entry_alloc_count", n_alloc - a0, 1);
        check_eq("entry_assigned_slot", bus.assigned_slot, 2);
        check_eq("entry_car_total", bus.car_total, 1);
        check_eq("entry_gate_cycles", n_egate - eg0, OPEN);
        check_eq("alloc_to_open_latency", last_erise - last_alloc, 2);

        // Lot full: no request, lot_full while the car waits.
        a0 = n_alloc; eg0 = n_egate;
        bus.slot_available = 0;
        bus.entry_sensor = 1;
        repeat (12) tick();
        check_eq("full_lot_full_high", bus.lot_full, 1);
        bus.entry_sensor = 0;
        repeat (15) tick();
        check_eq("full_lot_full_low", bus.lot_full, 0);
        check_eq("full_alloc_count", n_alloc - a0, 0);
        check_eq("full_gate_cycles", n_egate - eg0, 0);
        bus.slot_available = 1;

        // Exit with slot 3 keyed.
        f0 = n_free; xg0 = n_xgate;
        bus.exit_sel_in = 3;
        bus.exit_sensor = 1;
        repeat (6) tick();
        bus.exit_sel_in = 0;
        bus.exit_sensor = 0;
        repeat (25) tick();
        check_eq("exit_free_count", n_free - f0, 1);
        check_eq("exit_car_select_held", bus.exit_car_select, 3);
        check_eq("exit_gate_cycles", n_xgate - xg0, OPEN);
        check_eq("free_to_open_latency", last_xrise - last_free, 1);

        // Simultaneous entry and exit.
        a0 = n_alloc; f0 = n_free; eg0 = n_egate; xg0 = n_xgate;
        bus.entry_sensor = 1;
        bus.exit_sensor  = 1;
        repeat (6) tick();
        bus.entry_sensor = 0;
        bus.exit_sensor  = 0;
        repeat (30) tick();
        check_eq("both_alloc_count", n_alloc - a0, 1);
        check_eq("both_free_count", n_free - f0, 1);
        check_eq("both_same_cycle", last_alloc, last_free);
        check_eq("both_entry_gate", n_egate - eg0, OPEN);
        check_eq("both_exit_gate", n_xgate - xg0, OPEN);

`ifdef GATE_DEBOUNCE_EN
        // Short glitch is filtered, a stable pulse is accepted.
        a0 = n_alloc;
        bus.entry_sensor = 1;
        repeat (3) tick();
        bus.entry_sensor = 0;
        repeat (20) tick();
        check_eq("glitch_no_alloc", n_alloc - a0, 0);
        bus.entry_sensor = 1;
        repeat (4) tick();
        bus.entry_sensor = 0;
        repeat (30) tick();
        check_eq("stable_one_alloc", n_alloc - a0, 1);
`endif

        // Reset while the entry barrier is held open by a car.
        bus.entry_sensor = 1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (bus.entry_gate_open) found = 1;
        end
        check_eq("rst_mid_reached_open", found, 1);
        #2 rst = 1;
        #1 check_cleared("rst_mid");
        repeat (3) tick();
        rst = 0;
        a0 = n_alloc;
        repeat (30) tick();
        check_eq("rst_release_one_alloc", n_alloc - a0, 1);
        bus.entry_sensor = 0;
        repeat (30) tick();

        // Random traffic against the model.
        for (int s = 0; s < 250; s++) begin
            bus.entry_sensor   = 1'($urandom_range(0, 1));
            bus.exit_sensor    = 1'($urandom_range(0, 1));
            bus.slot_available = ($urandom_range(0, 3) != 0);
            for (int d = $urandom_range(1, 15); d > 0; d--) begin
                bus.allocated_slot = 2'($urandom);
                bus.exit_sel_in    = 2'($urandom);
                tick();
            end
        end
        bus.entry_sensor = 0;
        bus.exit_sensor  = 0;
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
